pipe_adder: RTL and testbench

- Parametrised, pipelined unsigned adder with valid/ready handshakes on input and output.
- Generalises the team's 4-bit combinational adder to WIDTH bits plus a carry-in.
- The carry chain is split into SEG-bit segments, one register stage per segment, so wide adds close timing.
- Sits between producer/consumer stream blocks; accepts one operand pair per cycle at full throughput.

---
 rtl/pipe_adder.sv | 204 ++++++++++++++++++++
 tb/tb_pipe_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined unsigned adder, WIDTH bits plus carry-in, with
// valid/ready handshakes on both sides.
//
// The carry chain is cut into SEG-bit segments. Stage k adds segment k of
// the operands using the carry registered by stage k-1 (stage 0 uses cin).
// Each stage registers:
//   - the partial sum accumulated so far;
//   - its carry-out;
//   - the operand segments still to be added.
// The last stage therefore holds the complete WIDTH+1 bit result.
// Latency is NSTG = WIDTH/SEG cycles, and one operand pair can be accepted
// per cycle.
//
// Flow control uses one enable for the whole pipeline. When the head holds
// a result that the consumer refuses, every stage holds and in_ready drops.
// Bubbles travel through the pipeline and are not collapsed.
//
// Optional build macro PIPE_ADDER_OVF_EN adds output ovf. It flags signed
// (two's-complement) overflow of a+b+cin at WIDTH bits, and it moves
// through the pipeline alongside sum.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (clears valids and all registers)
//   in_valid   operand pair present
//   in_ready   block can accept this cycle (combinational, 1 during rst)
//   a, b       WIDTH-bit unsigned operands
//   cin        carry-in
//   out_valid  sum present
//   out_ready  consumer accepts this cycle
//   sum        a+b+cin, WIDTH+1 bits, MSB is carry-out
//   ovf        (PIPE_ADDER_OVF_EN only) signed overflow flag for sum
module pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSTG = WIDTH / SEG;

  if (SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_bad_cfg
    $error("pipe_adder: SEG must be in 1..WIDTH and divide WIDTH");
  end

  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           c);
    return {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, c};
  endfunction

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = rst || !stall;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    // RW: width of the operand bits not yet added when entering stage k.
    // PW: width of the partial sum that stage k holds.
    localparam int RW = WIDTH - k * SEG;
    localparam int PW = (k + 1) * SEG;

    logic [RW-1:0] ra_in;
    logic [RW-1:0] rb_in;
    logic          c_in;
    logic          v_in;
    logic [SEG:0]  seg_sum;
    logic [PW-1:0] ps_new;
    logic [PW-1:0] ps_d;
    logic [PW-1:0] ps_q;
    logic          cy_d;
    logic          cy_q;
    logic          vld_d;
    logic          vld_q;

    if (k == 0) begin : g_head
      assign ra_in  = a;
      assign rb_in  = b;
      assign c_in   = cin;
      assign v_in   = in_valid;
      assign ps_new = seg_sum[SEG-1:0];
    end else begin : g_tail
      assign ra_in  = g_stg[k-1].g_rem.ra_q;
      assign rb_in  = g_stg[k-1].g_rem.rb_q;
      assign c_in   = g_stg[k-1].cy_q;
      assign v_in   = g_stg[k-1].vld_q;
      assign ps_new = {seg_sum[SEG-1:0], g_stg[k-1].ps_q};
    end

    assign seg_sum = seg_add(ra_in[SEG-1:0], rb_in[SEG-1:0], c_in);

    // Data loads only for a valid beat, so a bubble leaves the previous
    // result visible at the output.
    always_comb begin
      vld_d = vld_q;
      ps_d  = ps_q;
      cy_d  = cy_q;
      if (adv) begin
        vld_d = v_in;
        if (v_in) begin
          ps_d = ps_new;
          cy_d = seg_sum[SEG];
        end
      end
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        ps_q  <= '0;
        cy_q  <= 1'b0;
      end else begin
        vld_q <= vld_d;
        ps_q  <= ps_d;
        cy_q  <= cy_d;
      end
    end

    // Operand bits above this segment are delayed for the later stages.
    // The last stage has nothing left to carry.
    if (k < NSTG - 1) begin : g_rem
      logic [RW-SEG-1:0] ra_d;
      logic [RW-SEG-1:0] ra_q;
      logic [RW-SEG-1:0] rb_d;
      logic [RW-SEG-1:0] rb_q;

      always_comb begin
        ra_d = ra_q;
        rb_d = rb_q;
        if (adv && v_in) begin
          ra_d = ra_in[RW-1:SEG];
          rb_d = rb_in[RW-1:SEG];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
        end else begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].vld_q;
  assign sum       = {g_stg[NSTG-1].cy_q, g_stg[NSTG-1].ps_q};

`ifdef PIPE_ADDER_OVF_EN
  function automatic logic ovf_calc(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic ovf_new;
  logic ovf_d;
  logic ovf_q;

  // The last stage still sees the operand sign bits (top of its segment)
  // and produces result bit WIDTH-1. The flag is computed there, so it
  // lands in the same cycle as sum.
  assign ovf_new = ovf_calc(g_stg[NSTG-1].ra_in[SEG-1],
                            g_stg[NSTG-1].rb_in[SEG-1],
                            g_stg[NSTG-1].seg_sum[SEG-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (adv && g_stg[NSTG-1].v_in) begin
      ovf_d = ovf_new;
    end
  end

  // ---- overflow flag register boundary (aligned with last stage) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed bench for pipe_adder at WIDTH=8, SEG=4 (latency 2).
// Inputs change 1 time unit after the rising edge. Outputs are checked
// after the combinational paths settle.
module tb_pipe_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
`ifdef PIPE_ADDER_OVF_EN
  logic       ovf;
`endif

  int total;
  int bad;

  pipe_adder #(.WIDTH(8), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic vv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = vv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  va [4];
  logic [7:0]  vb [4];
  logic        vc [4];
  logic [31:0] vs [4];
  logic [15:0] rdy_pat;

  initial begin
    int   ii;
    int   oi;
    logic prev_stall;
    logic [8:0] prev_sum;

    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(8'd0, 8'd0, 1'b0, 1'b0);

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Single beat 1+2: valid exactly two edges after acceptance
    drive(8'd1, 8'd2, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    chk("t1_early_valid", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum", 32'(sum), 32'h003);
    step();
    chk("t1_bubble_valid", 32'(out_valid), 32'd0);
    chk("t1_bubble_hold", 32'(sum), 32'h003);

    // Inter-segment carry
    drive(8'h0F, 8'h01, 1'b0, 1'b1);
    step();
    drive(8'hFF, 8'h01, 1'b1, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    chk("carry_a_valid", 32'(out_valid), 32'd1);
    chk("carry_a_sum", 32'(sum), 32'h010);
    step();
    chk("carry_b_valid", 32'(out_valid), 32'd1);
    chk("carry_b_sum", 32'(sum), 32'h101);
    step();

    // Back-to-back, full throughput
    va[0] = 8'd4;   vb[0] = 8'd5;   vc[0] = 1'b0; vs[0] = 32'd9;
    va[1] = 8'd15;  vb[1] = 8'd1;   vc[1] = 1'b0; vs[1] = 32'd16;
    va[2] = 8'd10;  vb[2] = 8'd11;  vc[2] = 1'b0; vs[2] = 32'd21;
    va[3] = 8'd255; vb[3] = 8'd255; vc[3] = 1'b1; vs[3] = 32'd511;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], vc[i], 1'b1);
      step();
      if (i >= 1) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_sum", 32'(sum), vs[i-1]);
      end
    end
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    step();
    chk("b2b_last_valid", 32'(out_valid), 32'd1);
    chk("b2b_last_sum", 32'(sum), vs[3]);
    step();
    chk("b2b_drained", 32'(out_valid), 32'd0);

    // Backpressure: pairs (i, 2i), out_ready pattern from LSB upward
    rdy_pat    = 16'b1101_0110_1010_1001;
    ii         = 1;
    oi         = 0;
    prev_stall = 1'b0;
    prev_sum   = sum;
    for (int c = 0; c < 40 && oi < 6; c++) begin
      out_ready = (c < 16) ? rdy_pat[c] : 1'b1;
      if (ii <= 6) drive(8'(ii), 8'(2 * ii), 1'b0, 1'b1);
      else         drive(8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      if (prev_stall) chk("bp_hold_sum", 32'(sum), 32'(prev_sum));
      chk("bp_in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        chk("bp_out_sum", 32'(sum), 32'(3 * (oi + 1)));
        oi++;
      end
      if (in_valid && in_ready) ii++;
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      step();
    end
    chk("bp_out_count", 32'(oi), 32'd6);
    chk("bp_in_count", 32'(ii), 32'd7);
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset mid-flight; an input offered during rst is dropped
    drive(8'd7, 8'd7, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    drive(8'd9, 8'd9, 1'b0, 1'b1);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    step();
    chk("mid_rst_after1", 32'(out_valid), 32'd0);
    step();
    chk("mid_rst_after2", 32'(out_valid), 32'd0);
    chk("mid_rst_after2_sum", 32'(sum), 32'd0);
    drive(8'd3, 8'd4, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    chk("post_rst_early", 32'(out_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'd7);
    step();

`ifdef PIPE_ADDER_OVF_EN
    // Signed overflow flag
    drive(8'h7F, 8'h01, 1'b0, 1'b1);
    step();
    drive(8'h80, 8'hFF, 1'b0, 1'b1);
    step();
    chk("ovf1_sum", 32'(sum), 32'h080);
    chk("ovf1_flag", 32'(ovf), 32'd1);
    drive(8'h10, 8'h20, 1'b0, 1'b1);
    step();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    chk("ovf2_sum", 32'(sum), 32'h17F);
    chk("ovf2_flag", 32'(ovf), 32'd1);
    step();
    chk("ovf3_sum", 32'(sum), 32'h030);
    chk("ovf3_flag", 32'(ovf), 32'd0);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
